mbinit_repairval_module: RTL and testbench

//  MBINIT.REPAIRVAL sequencer: next MBINIT sub-state after REPAIRCLK, started by the REPAIRCLK end flag.

---
 rtl/mbinit_repairval_module.sv | 119 +++++++++++
 tb/tb_mbinit_repairval_module.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mbinit_repairval_module.sv
// rtl/mbinit_repairval_module.sv - MBINIT.REPAIRVAL sideband handshake and valid-pattern sequencer
module mbinit_repairval_module #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd8000,
    parameter int          CNT_W          = 16
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       i_MBINIT_REPAIRCLK_end,
    input  logic       i_VAL_Pattern_done,
    input  logic [3:0] i_Rx_SbMessage,
    input  logic       i_msg_valid,
    input  logic       i_Busy_SideBand,
    input  logic       i_falling_edge_busy,
    input  logic       i_VAL_result_logged,
    output logic       o_train_error_req,
    output logic       o_MBINIT_REPAIRVAL_Pattern_En,
    output logic       o_MBINIT_REPAIRVAL_Module_end,
    output logic [3:0] o_TX_SbMessage,
    output logic       o_ValidOutDatat_Module
);

    localparam logic [3:0] INIT_REQ_C    = 4'h1;
    localparam logic [3:0] INIT_RESP_C   = 4'h2;
    localparam logic [3:0] RESULT_REQ_C  = 4'h3;
    localparam logic [3:0] RESULT_RESP_C = 4'h4;
    localparam logic [3:0] DONE_REQ_C    = 4'h5;
    localparam logic [3:0] DONE_RESP_C   = 4'h6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 16'd1);

    typedef enum logic [3:0] {
        IDLE, INIT_REQ, WAIT_RESP, VALPATTERN, CHK_BUSY_RES, RESULT_REQ,
        CHECK_RESULT, CHK_BUSY_DONE, DONE_REQ, DONE, ERROR
    } state_t;

    state_t           state, ns;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       exp_resp;
    logic             result_q;
    logic             resp_ok;
    logic             en;

    assign en = i_MBINIT_REPAIRCLK_end;
    // Only the response matching the last request sent is accepted; other codes are noise.
    assign resp_ok = i_msg_valid && (i_Rx_SbMessage == exp_resp);

    always_comb begin
        ns = state;
        if (!en) begin
            ns = IDLE;
        end else begin
            case (state)
                IDLE:          if (!i_Busy_SideBand) ns = INIT_REQ;
                INIT_REQ:      if (i_falling_edge_busy) ns = WAIT_RESP;
                WAIT_RESP: begin
                    if (resp_ok) begin
                        case (exp_resp)
                            INIT_RESP_C:   ns = VALPATTERN;
                            RESULT_RESP_C: ns = CHECK_RESULT;
                            DONE_RESP_C:   ns = DONE;
                            default:       ns = ERROR;
                        endcase
                    end else if (cnt == CNT_LAST) begin
                        ns = ERROR;
                    end
                end
                VALPATTERN:    if (i_VAL_Pattern_done) ns = CHK_BUSY_RES;
                CHK_BUSY_RES:  if (!i_Busy_SideBand) ns = RESULT_REQ;
                RESULT_REQ:    if (i_falling_edge_busy) ns = WAIT_RESP;
                CHECK_RESULT:  ns = result_q ? CHK_BUSY_DONE : ERROR;
                CHK_BUSY_DONE: if (!i_Busy_SideBand) ns = DONE_REQ;
                DONE_REQ:      if (i_falling_edge_busy) ns = WAIT_RESP;
                DONE:          ns = DONE;
                ERROR:         ns = ERROR;
                default:       ns = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            exp_resp <= 4'h0;
            result_q <= 1'b0;
        end else begin
            state <= ns;
            cnt   <= (state == WAIT_RESP && ns == WAIT_RESP) ? cnt + 1'b1 : '0;
            if (ns == INIT_REQ)        exp_resp <= INIT_RESP_C;
            else if (ns == RESULT_REQ) exp_resp <= RESULT_RESP_C;
            else if (ns == DONE_REQ)   exp_resp <= DONE_RESP_C;
            else if (ns == IDLE)       exp_resp <= 4'h0;
            if (state == WAIT_RESP && resp_ok && exp_resp == RESULT_RESP_C)
                result_q <= i_VAL_result_logged;
        end
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            o_train_error_req             <= 1'b0;
            o_MBINIT_REPAIRVAL_Pattern_En <= 1'b0;
            o_MBINIT_REPAIRVAL_Module_end <= 1'b0;
            o_TX_SbMessage                <= 4'h0;
            o_ValidOutDatat_Module        <= 1'b0;
        end else begin
            o_train_error_req             <= (ns == ERROR) && (state != ERROR);
            o_MBINIT_REPAIRVAL_Pattern_En <= (ns == VALPATTERN);
            o_MBINIT_REPAIRVAL_Module_end <= (ns == DONE);
            o_ValidOutDatat_Module        <= (ns == INIT_REQ) || (ns == RESULT_REQ) || (ns == DONE_REQ);
            case (ns)
                INIT_REQ:   o_TX_SbMessage <= INIT_REQ_C;
                RESULT_REQ: o_TX_SbMessage <= RESULT_REQ_C;
                DONE_REQ:   o_TX_SbMessage <= DONE_REQ_C;
                default:    o_TX_SbMessage <= 4'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mbinit_repairval_module.sv
// tb/tb_mbinit_repairval_module.sv - directed self-checking bench for mbinit_repairval_module
module tb_mbinit_repairval_module;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       en, pat_done, msg_valid, busy, fe, result;
    logic [3:0] rx_msg;
    logic       err, pat_en, mod_end, tx_valid;
    logic [3:0] tx_msg;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 CLK = ~CLK;

    mbinit_repairval_module #(.TIMEOUT_CYCLES(16'd16), .CNT_W(16)) dut (
        .CLK                           (CLK),
        .rst_n                         (rst_n),
        .i_MBINIT_REPAIRCLK_end        (en),
        .i_VAL_Pattern_done            (pat_done),
        .i_Rx_SbMessage                (rx_msg),
        .i_msg_valid                   (msg_valid),
        .i_Busy_SideBand               (busy),
        .i_falling_edge_busy           (fe),
        .i_VAL_result_logged           (result),
        .o_train_error_req             (err),
        .o_MBINIT_REPAIRVAL_Pattern_En (pat_en),
        .o_MBINIT_REPAIRVAL_Module_end (mod_end),
        .o_TX_SbMessage                (tx_msg),
        .o_ValidOutDatat_Module        (tx_valid)
    );

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Packs every output as {err, pat_en, mod_end, tx_valid, tx_msg}.
    task automatic chk(input string tag, input logic [7:0] expv);
        logic [7:0] obs;
        obs = {err, pat_en, mod_end, tx_valid, tx_msg};
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [3:0] code);
        rx_msg = code; msg_valid = 1'b1;
        tick();
        msg_valid = 1'b0; rx_msg = 4'h0;
    endtask

    task automatic pulse_fe();
        fe = 1'b1;
        tick();
        fe = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; pat_done = 1'b0; msg_valid = 1'b0;
        busy = 1'b0; fe = 1'b0; result = 1'b0; rx_msg = 4'h0;
        #12;
        chk("reset", 8'h00);
        @(negedge CLK);
        rst_n = 1'b1;
        tick();
        chk("idle_disabled", 8'h00);

        // Happy path
        en = 1'b1;
        tick();                     chk("hp_init_req", 8'h11);
        tick();                     chk("hp_init_req_hold", 8'h11);
        pulse_fe();                 chk("hp_wait_init", 8'h00);
        tick();
        send(4'h2);                 chk("hp_valpattern", 8'h40);
        tick();                     chk("hp_valpattern_hold", 8'h40);
        pat_done = 1'b1;
        tick();                     chk("hp_chk_busy_res", 8'h00);
        pat_done = 1'b0;
        tick();                     chk("hp_result_req", 8'h13);
        pulse_fe();                 chk("hp_wait_result", 8'h00);
        result = 1'b1;
        send(4'h4);                 chk("hp_check_result", 8'h00);
        result = 1'b0;
        tick();                     chk("hp_chk_busy_done", 8'h00);
        tick();                     chk("hp_done_req", 8'h15);
        pulse_fe();                 chk("hp_wait_done", 8'h00);
        send(4'h6);                 chk("hp_done", 8'h20);
        tick(); tick();             chk("hp_done_held", 8'h20);

        // Failed valid-lane result
        en = 1'b0;
        tick();                     chk("abort_from_done", 8'h00);
        en = 1'b1;
        tick();                     chk("fl_init_req", 8'h11);
        pulse_fe();
        send(4'h2);                 chk("fl_valpattern", 8'h40);
        pat_done = 1'b1; tick(); pat_done = 1'b0;
        tick();                     chk("fl_result_req", 8'h13);
        pulse_fe();
        result = 1'b0;
        send(4'h4);                 chk("fl_check_result", 8'h00);
        tick();                     chk("fl_error_pulse", 8'h80);
        tick();                     chk("fl_error_quiet", 8'h00);
        tick();                     chk("fl_error_held", 8'h00);

        // Timeout: error exactly 16 cycles after WAIT_RESP entry
        en = 1'b0; tick(); en = 1'b1;
        tick();                     chk("to_init_req", 8'h11);
        pulse_fe();
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk($sformatf("to_wait_%0d", i), 8'h00);
        end
        tick();                     chk("to_error_pulse", 8'h80);
        tick();                     chk("to_error_quiet", 8'h00);

        // Response on the timeout cycle wins
        en = 1'b0; tick(); en = 1'b1;
        tick();
        pulse_fe();
        repeat (15) tick();
        send(4'h2);                 chk("to_resp_wins", 8'h40);

        // Abort during VALPATTERN, then re-enable
        en = 1'b0;
        tick();                     chk("ab_idle", 8'h00);
        en = 1'b1;
        tick();                     chk("ab_init_resent", 8'h11);

        // Noise: done_resp while waiting for init_resp is ignored
        pulse_fe();
        send(4'h6);                 chk("nz_done_ignored", 8'h00);
        tick();                     chk("nz_still_wait", 8'h00);
        send(4'h2);                 chk("nz_init_resp_ok", 8'h40);

        // Asynchronous reset while outputs are active
        @(posedge CLK); #2;
        rst_n = 1'b0;
        #1;                         chk("async_reset", 8'h00);
        en = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
        send(4'h2);                 chk("late_resp_ignored", 8'h00);

        // Busy gating in IDLE
        busy = 1'b1; en = 1'b1;
        tick();                     chk("bg_busy_idle", 8'h00);
        tick();                     chk("bg_busy_idle2", 8'h00);
        busy = 1'b0;
        tick();                     chk("bg_init_req", 8'h11);

        // Falling edge outside a request state is ignored
        pulse_fe();
        pulse_fe();                 chk("fe_ignored_in_wait", 8'h00);
        send(4'h2);                 chk("fe_then_valpattern", 8'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
